// File: rtl/cu33_buf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu33_buf_pkg : widths shared by the syncfifo and its read-side stream buffer
// Revision     : 1.0
// ---------------------------------------------------------------------------
package cu33_buf_pkg;

  localparam int BUF_DATA_WIDTH = 25;
  localparam int BUF_ADDR_WIDTH = 3;
  localparam int BUF_DEPTH      = 2;

  typedef logic [1:0] buf_cnt_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rd_stream : drains a syncfifo into a 2-entry buffer, valid/ready output
// Revision       : 1.0
// ---------------------------------------------------------------------------
module fifo_rd_stream
  import cu33_buf_pkg::*;
#(
  parameter int DWIDTH = BUF_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rden,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
);

  buf_cnt_t          cnt;
  logic              infl;
  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] tail;
  logic              pop;
  logic [2:0]        level;

  assign pop     = m_valid & m_ready;
  assign level   = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  assign m_valid = (cnt != 2'd0);
  assign m_data  = head;

  // Only issue a read when the word it returns is guaranteed a free slot.
  assign fifo_rden = ~fifo_empty & ~flush & ~rst & (level <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      infl <= 1'b0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      cnt  <= '0;
      infl <= 1'b0;
    end else begin
      infl <= fifo_rden;
      cnt  <= level[1:0];
      if (infl) begin
        // Arriving word goes straight to head when head is empty or leaving.
        if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
          head <= fifo_rdata;
        end else begin
          tail <= fifo_rdata;
        end
      end
      if (pop && (cnt == 2'd2)) begin
        head <= tail;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream : syncfifo model -> fifo_rd_stream, directed checks
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  logic          push;
  logic [DW-1:0] push_data;
  logic          fifo_clr;
  logic [DW-1:0] mem [8];
  logic [3:0]    wp, rp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] obs[$];
  int            obs_cyc[$];
  int            rden_cyc[$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rden  (fifo_rden),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  // syncfifo model, depth 8, registered read data
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[2:0]] <= push_data;
        wp <= wp + 4'd1;
      end
      if (fifo_rden) begin
        fifo_rdata <= mem[rp[2:0]];
        rp <= rp + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    check("rden_when_empty", {31'd0, fifo_rden & fifo_empty}, 32'd0);
    check("cnt_le_2", {31'd0, (dut.cnt <= 2'd2)}, 32'd1);
    if (prev_hold) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_data", {7'd0, m_data}, {7'd0, prev_data});
    end
    prev_hold = m_valid & ~m_ready & ~flush & ~rst;
    prev_data = m_data;
    if (fifo_rden) rden_cyc.push_back(cyc);
    if (m_valid && m_ready && !flush && !rst) begin
      obs.push_back(m_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k = 0;
    while ((obs.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    sample();
    check(tag, obs.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ob, rb, bad, npush;
    logic [DW-1:0] nxt;

    rst = 1'b1; fifo_clr = 1'b1; flush = 1'b0; m_ready = 1'b0;
    push = 1'b0; push_data = '0;
    tick(); tick();
    sample();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {7'd0, m_data}, 32'd0);
    check("rst_rden", {31'd0, fifo_rden}, 32'd0);
    tick();
    rst = 1'b0; fifo_clr = 1'b0;

    // Streaming at full rate
    m_ready = 1'b1;
    ob = obs.size(); rb = rden_cyc.size();
    for (int k = 1; k <= 8; k++) begin
      push = 1'b1; push_data = DW'(k);
      tick();
    end
    push = 1'b0;
    wait_obs("t1_count", ob + 8, 40);
    for (int i = 0; i < 8; i++) check("t1_data", {7'd0, obs[ob+i]}, i + 1);
    check("t1_back_to_back", obs_cyc[ob+7] - obs_cyc[ob], 7);
    check("t1_latency", obs_cyc[ob] - rden_cyc[rb], 2);
    check("t1_idle_valid", {31'd0, m_valid}, 32'd0);

    // Back-pressure: buffer fills to two, then drains in order
    tick();
    m_ready = 1'b0;
    ob = obs.size(); rb = rden_cyc.size();
    for (int k = 1; k <= 8; k++) begin
      push = 1'b1; push_data = DW'(k);
      tick();
    end
    push = 1'b0;
    tick(); tick();
    sample();
    check("t2_rden_pulses", rden_cyc.size() - rb, 2);
    check("t2_cnt", {30'd0, dut.cnt}, 32'd2);
    check("t2_valid", {31'd0, m_valid}, 32'd1);
    check("t2_head", {7'd0, m_data}, 32'd1);
    tick();
    m_ready = 1'b1;
    wait_obs("t2_count", ob + 8, 40);
    for (int i = 0; i < 8; i++) check("t2_data", {7'd0, obs[ob+i]}, i + 1);

    // Toggling ready with continuous push
    ob = obs.size(); npush = 0; nxt = DW'(100);
    tick();
    for (int k = 0; k < 30; k++) begin
      m_ready = ~m_ready;
      if ((wp - rp) < 4'd8) begin
        push = 1'b1; push_data = nxt; nxt = nxt + DW'(1); npush++;
      end else begin
        push = 1'b0;
      end
      tick();
    end
    push = 1'b0;
    for (int k = 0; k < 60 && obs.size() < ob + npush; k++) begin
      m_ready = ~m_ready;
      tick();
    end
    sample();
    check("t3_count", obs.size(), ob + npush);
    check("t3_first", {7'd0, obs[ob]}, 32'd100);
    bad = 0;
    for (int i = ob + 1; i < obs.size(); i++) if (obs[i] != obs[i-1] + DW'(1)) bad++;
    check("t3_increment", bad, 0);

    // Flush with one buffered word and one read in flight
    tick();
    m_ready = 1'b0;
    tick();
    ob = obs.size();
    push = 1'b1; push_data = DW'(200); tick();
    push_data = DW'(201); tick();
    push_data = DW'(202); tick();
    push = 1'b0; flush = 1'b1;
    sample();
    check("t4_pre_cnt", {30'd0, dut.cnt}, 32'd1);
    check("t4_pre_infl", {31'd0, dut.infl}, 32'd1);
    check("t4_rden_in_flush", {31'd0, fifo_rden}, 32'd0);
    tick();
    flush = 1'b0;
    sample();
    check("t4_valid_cleared", {31'd0, m_valid}, 32'd0);
    check("t4_cnt_cleared", {30'd0, dut.cnt}, 32'd0);
    tick();
    m_ready = 1'b1;
    push = 1'b1; push_data = DW'(203); tick();
    push_data = DW'(204); tick();
    push = 1'b0;
    wait_obs("t4_count", ob + 3, 30);
    for (int i = 0; i < 3; i++) check("t4_resume", {7'd0, obs[ob+i]}, 202 + i);

    // Reset with a full buffer
    tick();
    m_ready = 1'b0;
    ob = obs.size();
    push = 1'b1; push_data = DW'(300); tick();
    push_data = DW'(301); tick();
    push_data = DW'(302); tick();
    push = 1'b0;
    repeat (4) tick();
    sample();
    check("t5_pre_cnt", {30'd0, dut.cnt}, 32'd2);
    check("t5_pre_head", {7'd0, m_data}, 32'd300);
    tick();
    rst = 1'b1;
    sample();
    check("t5_rden_in_rst", {31'd0, fifo_rden}, 32'd0);
    tick();
    rst = 1'b0;
    sample();
    check("t5_valid_after_rst", {31'd0, m_valid}, 32'd0);
    check("t5_data_after_rst", {7'd0, m_data}, 32'd0);
    check("t5_infl_after_rst", {31'd0, dut.infl}, 32'd0);
    tick();
    m_ready = 1'b1;
    wait_obs("t5_count", ob + 1, 20);
    check("t5_survivor", {7'd0, obs[ob]}, 32'd302);
    repeat (4) tick();
    sample();
    check("t5_no_extra", obs.size(), ob + 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
